// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals shared between the two requesters,
// mem_arbiter and the single-port memory.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic                  req0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  ack0;
    logic [DATA_WIDTH-1:0] rdata0;

    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata1;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;
    logic                  gnt;

    // Arbiter side
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, rdata0, ack1, rdata1,
        output mem_we, mem_addr, mem_data,
        output busy, gnt
    );

    // Requester side
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, rdata0, ack1, rdata1,
        input  busy, gnt
    );

    // Memory side
    modport mem (
        input  mem_we, mem_addr, mem_data,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// Each access takes three cycles: IDLE (arbitrate), ACCESS, DONE (ack pulse).
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                state;
    logic                  prio;

    logic                  win_valid;
    logic                  win_idx;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    // Single requester wins outright; on contention the favoured one wins.
    always_comb begin
        win_valid = bus.req0 | bus.req1;
        win_idx   = (bus.req0 & bus.req1) ? prio : bus.req1;
        win_we    = win_idx ? bus.we1    : bus.we0;
        win_addr  = win_idx ? bus.addr1  : bus.addr0;
        win_data  = win_idx ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            prio         <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
            bus.ack0     <= 1'b0;
            bus.ack1     <= 1'b0;
            bus.gnt      <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.mem_we <= 1'b0;
                    if (win_valid) begin
                        bus.gnt      <= win_idx;
                        bus.mem_addr <= win_addr;
                        bus.mem_data <= win_data;
                        bus.mem_we   <= win_we;
                        bus.busy     <= 1'b1;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Memory captures addr/data/we on this edge.
                    bus.mem_we <= 1'b0;
                    bus.ack0   <= ~bus.gnt;
                    bus.ack1   <= bus.gnt;
                    prio       <= ~bus.gnt;
                    state      <= DONE;
                end
                DONE: begin
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.mem_we <= 1'b0;
                    bus.ack0   <= 1'b0;
                    bus.ack1   <= 1'b0;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Registered memory output is only meaningful alongside the matching ack.
    assign bus.rdata0 = bus.mem_rdata;
    assign bus.rdata1 = bus.mem_rdata;

endmodule
